// File: rtl/fifo_stream_reader.sv
//------------------------------------------------------------------------------
// Module  : fifo_stream_reader
// Brief   : Drains a synchronous FIFO into a valid/ready stream through a
//           2-entry skid buffer; frames PKT_LEN-word packets and counts words.
//           Optional head-word parity output m_par when FIFO_RD_PARITY_EN is
//           defined.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fifo_stream_reader #(
  parameter int WIDTH     = 8,
  parameter int PKT_LEN   = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fifo_empty,
  output logic                 fifo_rd_en,
  input  logic [WIDTH-1:0]     fifo_r_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [WIDTH-1:0]     m_data,
  output logic                 m_last,
  output logic [CNT_WIDTH-1:0] rd_count
`ifdef FIFO_RD_PARITY_EN
  ,
  output logic                 m_par
`endif
);

  localparam int                 c_PKT_W    = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [c_PKT_W-1:0] c_LAST_IDX = c_PKT_W'(PKT_LEN - 1);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  occ_t                 r_occ;
  occ_t                 w_occ_next;
  logic                 r_inflight;
  logic                 w_pop;
  logic [1:0]           w_fill;
  logic                 w_wr_slot;
  logic [WIDTH-1:0]     r_buf0;
  logic [WIDTH-1:0]     r_buf1;
  logic [c_PKT_W-1:0]   r_pkt_idx;
  logic [CNT_WIDTH-1:0] r_rd_count;

  // w_fill is the occupancy once this cycle's capture and pop have settled;
  // a new read is only allowed if that leaves room for the returning word.
  always_comb begin
    w_pop      = (r_occ != EMPTY) & m_ready;
    w_fill     = 2'(r_occ) + {1'b0, r_inflight} - {1'b0, w_pop};
    fifo_rd_en = !rst & !fifo_empty & (w_fill < 2'd2);
    w_wr_slot  = (r_occ == TWO) | ((r_occ == ONE) & !w_pop);
    case (w_fill)
      2'd0:    w_occ_next = EMPTY;
      2'd1:    w_occ_next = ONE;
      default: w_occ_next = TWO;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_occ      <= EMPTY;
      r_inflight <= 1'b0;
    end else begin
      r_occ      <= w_occ_next;
      r_inflight <= fifo_rd_en;
    end
  end

  // A capture into slot 0 deliberately overrides the shift, so a word that
  // arrives while the only buffered word is popped becomes the new head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf0 <= '0;
      r_buf1 <= '0;
    end else begin
      if (w_pop) begin
        r_buf0 <= r_buf1;
      end
      if (r_inflight) begin
        if (w_wr_slot) begin
          r_buf1 <= fifo_r_data;
        end else begin
          r_buf0 <= fifo_r_data;
        end
      end
    end
  end

`ifdef FIFO_RD_PARITY_EN
  logic r_par0;
  logic r_par1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_par0 <= 1'b0;
      r_par1 <= 1'b0;
    end else begin
      if (w_pop) begin
        r_par0 <= r_par1;
      end
      if (r_inflight) begin
        if (w_wr_slot) begin
          r_par1 <= ^fifo_r_data;
        end else begin
          r_par0 <= ^fifo_r_data;
        end
      end
    end
  end

  assign m_par = r_par0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pkt_idx  <= '0;
      r_rd_count <= '0;
    end else if (w_pop) begin
      r_rd_count <= r_rd_count + CNT_WIDTH'(1);
      if (r_pkt_idx == c_LAST_IDX) begin
        r_pkt_idx <= '0;
      end else begin
        r_pkt_idx <= r_pkt_idx + c_PKT_W'(1);
      end
    end
  end

  assign m_valid  = (r_occ != EMPTY);
  assign m_data   = r_buf0;
  assign m_last   = m_valid & (r_pkt_idx == c_LAST_IDX);
  assign rd_count = r_rd_count;

endmodule

`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
//------------------------------------------------------------------------------
// Module  : tb_fifo_stream_reader
// Brief   : Directed self-checking bench for fifo_stream_reader with a small
//           behavioural FIFO model on its read port.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fifo_stream_reader;

  logic        clk;
  logic        rst;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [7:0]  fifo_r_data;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic        m_last;
  logic [15:0] rd_count;
`ifdef FIFO_RD_PARITY_EN
  logic        m_par;
`endif

  int tests;
  int fails;

  fifo_stream_reader #(
    .WIDTH    (8),
    .PKT_LEN  (4),
    .CNT_WIDTH(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_r_data(fifo_r_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .rd_count   (rd_count)
`ifdef FIFO_RD_PARITY_EN
    ,
    .m_par      (m_par)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural FIFO: one-cycle read latency, data held until the next read.
  logic [7:0] mem [0:255];
  int         wr_ptr;
  int         rd_ptr;
  int         rd_empty_err;

  assign fifo_empty = (wr_ptr == rd_ptr);

  initial begin
    rd_ptr       = 0;
    rd_empty_err = 0;
    fifo_r_data  = 8'h00;
  end

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      if (fifo_empty) begin
        rd_empty_err <= rd_empty_err + 1;
      end else begin
        fifo_r_data <= mem[rd_ptr[7:0]];
        rd_ptr      <= rd_ptr + 1;
      end
    end
  end

  task automatic push(input logic [7:0] w);
    mem[wr_ptr[7:0]] = w;
    wr_ptr           = wr_ptr + 1;
  endtask

  // Capture log filled by run_cycles; mode 0: ready low, 1: high, 2: alternate.
  logic [7:0] rx_data [0:31];
  logic       rx_last [0:31];
  logic       rx_par  [0:31];
  int         rx_cyc  [0:31];
  int         rx_n;
  int         rd_pulses;
  int         rd_first;
  int         v_first;
  int         v_cnt;

  task automatic run_cycles(input int ncyc, input int mode);
    rx_n      = 0;
    rd_pulses = 0;
    rd_first  = -1;
    v_first   = -1;
    v_cnt     = 0;
    for (int i = 0; i < ncyc; i++) begin
      m_ready = (mode == 1) || (mode == 2 && (i % 2) == 0);
      #1;
      if (fifo_rd_en) begin
        rd_pulses++;
        if (rd_first < 0) rd_first = i;
      end
      if (m_valid) begin
        v_cnt++;
        if (v_first < 0) v_first = i;
      end
      if (m_valid && m_ready && rx_n < 32) begin
        rx_data[rx_n] = m_data;
        rx_last[rx_n] = m_last;
`ifdef FIFO_RD_PARITY_EN
        rx_par[rx_n]  = m_par;
`else
        rx_par[rx_n]  = 1'b0;
`endif
        rx_cyc[rx_n]  = i;
        rx_n++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    #1;
    tests++;
    if (m_valid !== 1'b0) begin
      fails++; $display("FAIL reset_m_valid: got %b expected 0", m_valid);
    end
    tests++;
    if (m_data !== 8'h00 || m_last !== 1'b0) begin
      fails++; $display("FAIL reset_data_last: got data=%h last=%b expected 00/0", m_data, m_last);
    end
    tests++;
    if (rd_count !== 16'd0) begin
      fails++; $display("FAIL reset_rd_count: got %0d expected 0", rd_count);
    end
    // a word sits in the FIFO while reset is held: no read may be issued
    push(8'hA5);
    #1;
    tests++;
    if (fifo_rd_en !== 1'b0) begin
      fails++; $display("FAIL reset_rd_en: got %b expected 0", fifo_rd_en);
    end
    @(negedge clk);
    rst = 1'b0;
    run_cycles(6, 1);
    tests++;
    if (rx_n !== 1 || rx_data[0] !== 8'hA5) begin
      fails++; $display("FAIL reset_first_word: got n=%0d data=%h expected 1/a5", rx_n, rx_data[0]);
    end
  endtask

  task automatic test_basic_drain;
    for (int k = 0; k < 16; k++) push(8'h10 + 8'(k));
    run_cycles(30, 1);
    tests++;
    if (rx_n !== 16) begin
      fails++; $display("FAIL drain_count: got %0d words expected 16", rx_n);
    end
    for (int k = 0; k < 16; k++) begin
      tests++;
      if (rx_data[k] !== 8'h10 + 8'(k)) begin
        fails++; $display("FAIL drain_word%0d: got %h expected %h", k, rx_data[k], 8'h10 + 8'(k));
      end
    end
    tests++;
    if (rx_cyc[15] - rx_cyc[0] !== 15) begin
      fails++; $display("FAIL drain_throughput: got span %0d expected 15", rx_cyc[15] - rx_cyc[0]);
    end
    tests++;
    if (rd_count !== 16'd17) begin
      fails++; $display("FAIL drain_rd_count: got %0d expected 17", rd_count);
    end
    tests++;
    if (rd_empty_err !== 0) begin
      fails++; $display("FAIL drain_rd_when_empty: got %0d expected 0", rd_empty_err);
    end
  endtask

  task automatic test_backpressure;
    for (int k = 0; k < 8; k++) push(8'h20 + 8'(k));
    run_cycles(10, 0);
    tests++;
    if (rd_pulses !== 2) begin
      fails++; $display("FAIL bp_rd_pulses: got %0d expected 2", rd_pulses);
    end
    #1;
    tests++;
    if (m_valid !== 1'b1 || m_data !== 8'h20) begin
      fails++; $display("FAIL bp_hold: got valid=%b data=%h expected 1/20", m_valid, m_data);
    end
    run_cycles(20, 1);
    tests++;
    if (rx_n !== 8) begin
      fails++; $display("FAIL bp_count: got %0d words expected 8", rx_n);
    end
    for (int k = 0; k < 8; k++) begin
      tests++;
      if (rx_data[k] !== 8'h20 + 8'(k)) begin
        fails++; $display("FAIL bp_word%0d: got %h expected %h", k, rx_data[k], 8'h20 + 8'(k));
      end
    end
    tests++;
    if (rd_count !== 16'd25) begin
      fails++; $display("FAIL bp_rd_count: got %0d expected 25", rd_count);
    end
  endtask

  task automatic test_toggle_ready;
    // 25 words so far, so realign framing with 3 pops before the checked run
    for (int k = 0; k < 3; k++) push(8'hE0 + 8'(k));
    run_cycles(8, 1);
    for (int k = 0; k < 12; k++) push(8'h30 + 8'(k));
    run_cycles(40, 2);
    tests++;
    if (rx_n !== 12) begin
      fails++; $display("FAIL tog_count: got %0d words expected 12", rx_n);
    end
    for (int k = 0; k < 12; k++) begin
      tests++;
      if (rx_data[k] !== 8'h30 + 8'(k) || rx_last[k] !== ((k % 4) == 3)) begin
        fails++; $display("FAIL tog_word%0d: got %h last=%b expected %h last=%b",
                          k, rx_data[k], rx_last[k], 8'h30 + 8'(k), (k % 4) == 3);
      end
    end
    tests++;
    if (rd_count !== 16'd40) begin
      fails++; $display("FAIL tog_rd_count: got %0d expected 40", rd_count);
    end
  endtask

  task automatic test_empty_boundary;
    push(8'h55);
    run_cycles(8, 1);
    tests++;
    if (rd_first < 0 || v_first - rd_first !== 2) begin
      fails++; $display("FAIL empty_latency: got rd_en@%0d valid@%0d expected gap 2", rd_first, v_first);
    end
    tests++;
    if (v_cnt !== 1 || rx_n !== 1 || rx_data[0] !== 8'h55) begin
      fails++; $display("FAIL empty_single: got valid_cycles=%0d n=%0d data=%h expected 1/1/55",
                        v_cnt, rx_n, rx_data[0]);
    end
    tests++;
    if (rd_pulses !== 1) begin
      fails++; $display("FAIL empty_rd_pulses: got %0d expected 1", rd_pulses);
    end
  endtask

  task automatic test_reset_midstream;
    // 41 delivered so far (pkt_idx 1); two more pops bring pkt_idx to 3
    push(8'h5A);
    push(8'h5B);
    run_cycles(8, 1);
    for (int k = 0; k < 4; k++) push(8'h60 + 8'(k));
    run_cycles(4, 0);
    #1;
    tests++;
    if (m_valid !== 1'b1 || m_last !== 1'b1 || m_data !== 8'h60) begin
      fails++; $display("FAIL mid_pre: got valid=%b last=%b data=%h expected 1/1/60", m_valid, m_last, m_data);
    end
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if (m_valid !== 1'b0 || m_last !== 1'b0 || rd_count !== 16'd0 || m_data !== 8'h00) begin
      fails++; $display("FAIL mid_async: got valid=%b last=%b count=%0d data=%h expected 0/0/0/00",
                        m_valid, m_last, rd_count, m_data);
    end
    @(negedge clk);
    rst = 1'b0;
    run_cycles(10, 1);
    tests++;
    if (rx_n !== 2 || rx_data[0] !== 8'h62 || rx_data[1] !== 8'h63) begin
      fails++; $display("FAIL mid_resume: got n=%0d data=%h,%h expected 2/62,63", rx_n, rx_data[0], rx_data[1]);
    end
    tests++;
    if (rx_last[0] !== 1'b0 || rd_count !== 16'd2) begin
      fails++; $display("FAIL mid_frame: got last=%b count=%0d expected 0/2", rx_last[0], rd_count);
    end
  endtask

`ifdef FIFO_RD_PARITY_EN
  task automatic test_parity;
    logic [7:0] words [0:3];
    logic       pexp  [0:3];
    words[0] = 8'h00; pexp[0] = 1'b0;
    words[1] = 8'h01; pexp[1] = 1'b1;
    words[2] = 8'hFF; pexp[2] = 1'b0;
    words[3] = 8'h7F; pexp[3] = 1'b1;
    for (int k = 0; k < 4; k++) push(words[k]);
    run_cycles(10, 1);
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (rx_data[k] !== words[k] || rx_par[k] !== pexp[k]) begin
        fails++; $display("FAIL parity%0d: got %h par=%b expected %h par=%b",
                          k, rx_data[k], rx_par[k], words[k], pexp[k]);
      end
    end
  endtask
`endif

  initial begin
    tests   = 0;
    fails   = 0;
    wr_ptr  = 0;
    rst     = 1'b1;
    m_ready = 1'b0;
    test_reset();
    test_basic_drain();
    test_backpressure();
    test_toggle_ready();
    test_empty_boundary();
    test_reset_midstream();
`ifdef FIFO_RD_PARITY_EN
    test_parity();
`endif
    tests++;
    if (rd_empty_err !== 0) begin
      fails++; $display("FAIL rd_when_empty_total: got %0d expected 0", rd_empty_err);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
